// File: rtl/disp_pkg.sv
// disp_pkg: shared widths, commit-state encodings and a width helper for the display scanner
package disp_pkg;
    localparam int NIBBLE_W = 4;
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: free-running 0..PRESCALE-1 counter with a tick on the terminal count
module scan_prescaler
    import disp_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       tick_o,
    output logic [clog2(PRESCALE)-1:0] count_o
);
    localparam int CW = clog2(PRESCALE);
    logic [CW-1:0] count_q;
    assign tick_o  = count_q == CW'(PRESCALE - 1);
    assign count_o = count_q;
    // count up and wrap to zero in the tick cycle
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= tick_o ? '0 : count_q + 1'b1;
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: double-buffered multiplexed 7-segment scan controller (optional SCAN_BLANK_GAP_EN anti-ghost gap)
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int PRESCALE         = 50000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_i,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]        blank_i,
    output logic                         busy_o,
    output logic [NIBBLE_W-1:0]          nibble_o,
    output logic [NUM_DIGITS-1:0]        digit_en_o,
    output logic                         frame_o
);
    localparam int IW = clog2(NUM_DIGITS);
    localparam int CW = clog2(PRESCALE);
    logic                           tick, last, wrap, dark;
    logic [CW-1:0]                  count;
    logic [IW-1:0]                  idx_q;
    logic [0:0]                     state_q;
    logic                           frame_q;
    logic [NIBBLE_W*NUM_DIGITS-1:0] act_val_q, pend_val_q;
    logic [NUM_DIGITS-1:0]          act_blank_q, pend_blank_q, onehot, en;

    scan_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick),
        .count_o(count)
    );

    assign last = idx_q == IW'(NUM_DIGITS - 1);
    assign wrap = tick && last;

    // advance the digit slot on every prescaler tick
    always_ff @(posedge clk) begin
        if (rst)       idx_q <= '0;
        else if (tick) idx_q <= last ? '0 : idx_q + 1'b1;
    end

    // commit FSM: stage loads, publish at frame wrap, bypass when load meets the wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            frame_q      <= 1'b0;
            act_val_q    <= '0;
            act_blank_q  <= '1;
            pend_val_q   <= '0;
            pend_blank_q <= '0;
        end else begin
            frame_q <= wrap;
            if (wrap && load_i) begin
                act_val_q   <= value_i;
                act_blank_q <= blank_i;
                state_q     <= ST_IDLE;
            end else if (load_i) begin
                pend_val_q   <= value_i;
                pend_blank_q <= blank_i;
                state_q      <= ST_PENDING;
            end else if (wrap && state_q == ST_PENDING) begin
                act_val_q   <= pend_val_q;
                act_blank_q <= pend_blank_q;
                state_q     <= ST_IDLE;
            end
        end
    end

`ifdef SCAN_BLANK_GAP_EN
    assign dark = act_blank_q[idx_q] || count < CW'(PRESCALE / 8);
`else
    logic unused_count;
    assign unused_count = ^count;
    assign dark = act_blank_q[idx_q];
`endif

    assign onehot     = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    assign en         = dark ? '0 : onehot;
    assign digit_en_o = ANODE_ACTIVE_LOW ? ~en : en;
    assign nibble_o   = act_val_q[{idx_q, 2'b00} +: NIBBLE_W];
    assign busy_o     = state_q == ST_PENDING;
    assign frame_o    = frame_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench for display_scan_ctrl (PRESCALE=8, NUM_DIGITS=4, active-low anodes)
module tb_display_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_i = 1'b0;
    logic [15:0] value_i = '0;
    logic [3:0]  blank_i = '0;
    logic        busy_o, frame_o;
    logic [3:0]  nibble_o, digit_en_o;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] nib;
        logic [3:0] en;
    } exp_t;
    exp_t q[$];

    display_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(8), .ANODE_ACTIVE_LOW(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_i),
        .value_i   (value_i),
        .blank_i   (blank_i),
        .busy_o    (busy_o),
        .nibble_o  (nibble_o),
        .digit_en_o(digit_en_o),
        .frame_o   (frame_o)
    );

    always #5 clk = ~clk;

    task automatic push_frame(input logic [15:0] v, input logic [3:0] b);
        exp_t e;
        int k;
        for (int i = 0; i < 32; i++) begin
            k = i / 8;
            e.nib = v[4*k +: 4];
            e.en  = b[k] ? 4'hF : ~(4'b0001 << k);
`ifdef SCAN_BLANK_GAP_EN
            if (i % 8 == 0) e.en = 4'hF;
`endif
            q.push_back(e);
        end
    endtask

    task automatic wait_frame;
        int n = 0;
        @(negedge clk);
        while (frame_o !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_o !== 1'b1) begin
            errors++;
            $display("FAIL frame_timeout: frame_o %b after %0d cycles, required 1", frame_o, n);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] b);
        load_i  = 1'b1;
        value_i = v;
        blank_i = b;
        @(negedge clk);
        load_i  = 1'b0;
    endtask

    task automatic test_reset;
        logic fexp;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            fexp = (i % 32 == 0);
            checks++;
            if (digit_en_o !== 4'hF || busy_o !== 1'b0 || nibble_o !== 4'h0 || frame_o !== fexp) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: en %b busy %b nib %h frame %b, required 1111 0 0 %b",
                         i, digit_en_o, busy_o, nibble_o, frame_o, fexp);
            end
        end
    endtask

    task automatic test_load_scan;
        exp_t e;
        @(negedge clk);
        do_load(16'h4321, 4'b0000);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL load_busy: busy %b, required 1", busy_o);
        end
        push_frame(16'h4321, 4'b0000);
        wait_frame();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL load_commit_busy: busy %b, required 0", busy_o);
        end
        for (int i = 0; i < 32; i++) begin
            e = q.pop_front();
            checks++;
            if (nibble_o !== e.nib || digit_en_o !== e.en || frame_o !== (i == 0)) begin
                errors++;
                $display("FAIL scan_4321 cyc %0d: nib %h en %b frame %b, required %h %b %b",
                         i, nibble_o, digit_en_o, frame_o, e.nib, e.en, i == 0);
            end
            @(negedge clk);
        end
        checks++;
        if (frame_o !== 1'b1) begin
            errors++;
            $display("FAIL frame_period: frame %b 32 cycles later, required 1", frame_o);
        end
    endtask

    task automatic test_last_wins;
        exp_t e;
        repeat (3) @(negedge clk);
        do_load(16'h1111, 4'b0000);
        repeat (6) @(negedge clk);
        do_load(16'h2222, 4'b0000);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL last_wins_busy: busy %b, required 1", busy_o);
        end
        push_frame(16'h2222, 4'b0000);
        wait_frame();
        for (int i = 0; i < 32; i++) begin
            e = q.pop_front();
            checks++;
            if (nibble_o !== e.nib || digit_en_o !== e.en || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL last_wins cyc %0d: nib %h en %b busy %b, required %h %b 0",
                         i, nibble_o, digit_en_o, busy_o, e.nib, e.en);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bypass;
        exp_t e;
        wait_frame();
        repeat (31) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL bypass_pre_busy: busy %b, required 0", busy_o);
        end
        push_frame(16'h9876, 4'b0000);
        do_load(16'h9876, 4'b0000);
        checks++;
        if (frame_o !== 1'b1) begin
            errors++;
            $display("FAIL bypass_frame: frame %b, required 1", frame_o);
        end
        for (int i = 0; i < 32; i++) begin
            e = q.pop_front();
            checks++;
            if (nibble_o !== e.nib || digit_en_o !== e.en || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL bypass cyc %0d: nib %h en %b busy %b, required %h %b 0",
                         i, nibble_o, digit_en_o, busy_o, e.nib, e.en);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_blank;
        exp_t e;
        repeat (5) @(negedge clk);
        do_load(16'h5555, 4'b0100);
        push_frame(16'h5555, 4'b0100);
        wait_frame();
        for (int i = 0; i < 32; i++) begin
            e = q.pop_front();
            checks++;
            if (nibble_o !== e.nib || digit_en_o !== e.en) begin
                errors++;
                $display("FAIL blank cyc %0d: nib %h en %b, required %h %b",
                         i, nibble_o, digit_en_o, e.nib, e.en);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        repeat (9) @(negedge clk);
        do_load(16'hABCD, 4'b0000);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy: busy %b, required 1", busy_o);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (digit_en_o !== 4'hF || nibble_o !== 4'h0 || busy_o !== 1'b0 || frame_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_now: en %b nib %h busy %b frame %b, required 1111 0 0 0",
                     digit_en_o, nibble_o, busy_o, frame_o);
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if (digit_en_o !== 4'hF || nibble_o !== 4'h0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_dark cyc %0d: en %b nib %h busy %b, required 1111 0 0",
                         i, digit_en_o, nibble_o, busy_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_scan();
        test_last_wins();
        test_bypass();
        test_blank();
        test_reset_mid();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
